// File: rtl/wb_dec_pkg.sv
// Shared definitions for the Wishbone 1-master / 4-slave decoder.
//
// Contents:
//   tgt_t            3-bit target code type
//   TGT_S0..TGT_S3   slave targets 0..3
//   TGT_ERR          internal error responder (no slave matched)
//   CNT_W            width of the outstanding-request counter
//   decode()         address -> target code, lowest matching slave wins
package wb_dec_pkg;

    localparam int NUM_SLV = 4;
    localparam int CNT_W   = 4;

    typedef logic [2:0] tgt_t;

    localparam tgt_t TGT_S0  = 3'd0;
    localparam tgt_t TGT_S1  = 3'd1;
    localparam tgt_t TGT_S2  = 3'd2;
    localparam tgt_t TGT_S3  = 3'd3;
    localparam tgt_t TGT_ERR = 3'd4;

    // Base and mask are packed 4x32 vectors, slave i at [32i+31:32i].
    // Iterating downwards lets the lowest matching index overwrite the rest.
    function automatic tgt_t decode(
        input logic [31:0]  adr,
        input logic [127:0] base,
        input logic [127:0] mask
    );
        tgt_t tgt;
        tgt = TGT_ERR;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((adr & mask[32*i +: 32]) == (base[32*i +: 32] & mask[32*i +: 32]))
                tgt = tgt_t'(i);
        end
        return tgt;
    endfunction

endpackage

// File: rtl/wb_dec_outst_ctr.sv
// Outstanding-request tracker for the Wishbone decoder.
//
// Counts requests that were accepted but not yet answered, and, when the
// macro WB_DEC_TIMEOUT_EN is defined, runs a watchdog that retires a request
// whose slave never answers within TIMEOUT_CYC cycles.
//
// Ports:
//   clk        clock
//   rst_async  asynchronous reset, active-high
//   clr        synchronous clear (sync reset or master dropped CYC)
//   inc        a request was accepted this cycle
//   dec        a genuine response was delivered this cycle
//   cnt        number of outstanding requests
//   empty      cnt == 0
//   full       cnt == MAX_OUTST
//   timeout    watchdog retires one request this cycle (always 0 without
//              WB_DEC_TIMEOUT_EN)
module wb_dec_outst_ctr
    import wb_dec_pkg::*;
#(
    parameter int MAX_OUTST   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             empty,
    output logic             full,
    output logic             timeout
);

    logic dec_any;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(MAX_OUTST));

`ifdef WB_DEC_TIMEOUT_EN
    logic [7:0] wd;

    // Fires on the TIMEOUT_CYC-th silent cycle; a genuine response in the
    // same cycle wins and simply reloads the watchdog.
    assign timeout = !empty && !dec && (wd == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async)
            wd <= '0;
        else if (clr || empty || dec || timeout)
            wd <= '0;
        else
            wd <= wd + 8'd1;
    end
`else
    logic [7:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 8'(TIMEOUT_CYC);
    assign timeout            = 1'b0;
`endif

    assign dec_any = dec | timeout;

    // Accept and retire in the same cycle cancel out; the guards keep the
    // count inside 0..MAX_OUTST.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !dec_any && !full)
            cnt <= cnt + 1'b1;
        else if (dec_any && !inc && !empty)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/wb_dec_1m_4s.sv
// Pipelined Wishbone address decoder/router: one master, four slaves.
//
// Decodes the master address to a slave (or to an internal error responder
// when nothing matches), forwards requests, steers ACK/ERR/RD_DAT back from
// the slave that owns the outstanding requests, and stalls a request to a
// different target until the pipeline has drained.
//
// Optional macro: WB_DEC_TIMEOUT_EN enables a per-request watchdog that
// answers with ERR after TIMEOUT_CYC silent cycles.
//
// Ports:
//   CLK, RST_ASYNC (async, active-high), RST_SYNC (sync, active-high)
//   WB_SL_*   master-facing slave port (ADR/CYC/STB/WE/SEL/WR_DAT in,
//             STALL/ACK/ERR/RD_DAT out)
//   WB_M_*    slave-facing master port: ADR/WE/SEL/WR_DAT broadcast,
//             per-slave CYC/STB out, per-slave STALL/ACK/ERR/RD_DAT in
//             (RD_DAT slave i at [32i+31:32i])
module wb_dec_1m_4s
    import wb_dec_pkg::*;
#(
    parameter logic [127:0] SLV_BASE    = {32'h3000_0000, 32'h2000_0000,
                                           32'h1000_0000, 32'h0000_0000},
    parameter logic [127:0] SLV_MASK    = {4{32'hF000_0000}},
    parameter int           MAX_OUTST   = 4,
    parameter int           TIMEOUT_CYC = 255
) (
    input  logic         CLK,
    input  logic         RST_ASYNC,
    input  logic         RST_SYNC,
    input  logic [31:0]  WB_SL_ADR_IN,
    input  logic         WB_SL_CYC_IN,
    input  logic         WB_SL_STB_IN,
    input  logic         WB_SL_WE_IN,
    input  logic [3:0]   WB_SL_SEL_IN,
    input  logic [31:0]  WB_SL_WR_DAT_IN,
    output logic         WB_SL_STALL_OUT,
    output logic         WB_SL_ACK_OUT,
    output logic         WB_SL_ERR_OUT,
    output logic [31:0]  WB_SL_RD_DAT_OUT,
    output logic [31:0]  WB_M_ADR_OUT,
    output logic [3:0]   WB_M_CYC_OUT,
    output logic [3:0]   WB_M_STB_OUT,
    output logic         WB_M_WE_OUT,
    output logic [3:0]   WB_M_SEL_OUT,
    output logic [31:0]  WB_M_WR_DAT_OUT,
    input  logic [3:0]   WB_M_STALL_IN,
    input  logic [3:0]   WB_M_ACK_IN,
    input  logic [3:0]   WB_M_ERR_IN,
    input  logic [127:0] WB_M_RD_DAT_IN
);

    tgt_t             tgt;
    tgt_t             sel_reg;
    logic             err_pend;
    logic [CNT_W-1:0] outst_cnt;
    logic             empty;
    logic             full;
    logic             timeout;
    logic             sel_ack;
    logic             sel_err;
    logic [31:0]      sel_dat;
    logic             live;
    logic             resp_real;
    logic             resp;
    logic             block;
    logic             tgt_stall;
    logic             accept;

    assign tgt = decode(WB_SL_ADR_IN, SLV_BASE, SLV_MASK);

    // Response sources of the currently owning target. sel_reg only ever
    // holds 0..4, so bit 2 alone identifies the error responder.
    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        if (sel_reg[2]) begin
            sel_err = err_pend;
        end else begin
            sel_ack = WB_M_ACK_IN[sel_reg[1:0]];
            sel_err = WB_M_ERR_IN[sel_reg[1:0]];
            sel_dat = WB_M_RD_DAT_IN[{sel_reg[1:0], 5'b0} +: 32];
        end
    end

    // Responses are only meaningful while the master still holds the cycle
    // and something is outstanding; anything else is dropped.
    assign live      = WB_SL_CYC_IN && !empty;
    assign resp_real = live && (sel_ack || sel_err);
    assign resp      = resp_real || timeout;

    assign block     = (!empty && (tgt != sel_reg)) || (full && !resp);
    assign tgt_stall = !tgt[2] && WB_M_STALL_IN[tgt[1:0]];

    assign WB_SL_STALL_OUT = WB_SL_CYC_IN && (block || tgt_stall);
    assign accept          = WB_SL_CYC_IN && WB_SL_STB_IN && !WB_SL_STALL_OUT;

    // ACK+ERR together from one slave is a single, erroring response.
    assign WB_SL_ACK_OUT    = live && sel_ack && !sel_err;
    assign WB_SL_ERR_OUT    = live && (sel_err || timeout);
    assign WB_SL_RD_DAT_OUT = live ? sel_dat : '0;

    assign WB_M_ADR_OUT    = WB_SL_ADR_IN;
    assign WB_M_WE_OUT     = WB_SL_WE_IN;
    assign WB_M_SEL_OUT    = WB_SL_SEL_IN;
    assign WB_M_WR_DAT_OUT = WB_SL_WR_DAT_IN;

    // A slave keeps its CYC while it still owes responses, even when the
    // master has already moved on to a blocked request elsewhere.
    always_comb begin
        WB_M_STB_OUT = '0;
        WB_M_CYC_OUT = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            WB_M_STB_OUT[i] = WB_SL_CYC_IN && WB_SL_STB_IN &&
                              (tgt == tgt_t'(i)) && !block;
            WB_M_CYC_OUT[i] = WB_SL_CYC_IN &&
                              (((tgt == tgt_t'(i)) && !block) ||
                               (!empty && (sel_reg == tgt_t'(i))));
        end
    end

    // The error responder answers exactly one cycle after accepting.
    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            sel_reg  <= TGT_S0;
            err_pend <= 1'b0;
        end else if (RST_SYNC) begin
            sel_reg  <= TGT_S0;
            err_pend <= 1'b0;
        end else begin
            if (accept)
                sel_reg <= tgt;
            err_pend <= accept && (tgt == TGT_ERR);
        end
    end

    wb_dec_outst_ctr #(
        .MAX_OUTST   (MAX_OUTST),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_outst_ctr (
        .clk       (CLK),
        .rst_async (RST_ASYNC),
        .clr       (RST_SYNC || !WB_SL_CYC_IN),
        .inc       (accept),
        .dec       (resp_real),
        .cnt       (outst_cnt),
        .empty     (empty),
        .full      (full),
        .timeout   (timeout)
    );

endmodule
